// File: rtl/tl_get_put_master_pkg.sv
// Shared TileLink-UL definitions for the get/put master and the memory slaves.
//   - A/D channel opcodes and ENABLE/DISABLE levels
//   - master FSM state encoding
//   - tl_mask_f / tl_aligned_f: byte-lane mask generation and alignment test
//     for an access of 2^size bytes within a 64-bit beat
package tl_get_put_master_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam int unsigned TL_SRC_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } tl_master_state_e;

    // ((1 << (1 << size)) - 1) << addr_lo, truncated to the 8 byte lanes.
    function automatic logic [7:0] tl_mask_f(input logic [2:0] addr_lo,
                                             input logic [1:0] size);
        logic [15:0] m;
        m = ((16'd1 << (5'd1 << size)) - 16'd1) << addr_lo;
        return m[7:0];
    endfunction

    // The low address bits must be a multiple of the access size.
    function automatic logic tl_aligned_f(input logic [2:0] addr_lo,
                                          input logic [1:0] size);
        logic ok;
        unique case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (addr_lo[0]   == 1'b0);
            2'd2:    ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo      == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tl_get_put_master.sv
// TileLink-UL initiator, one outstanding transaction.
// Turns a valid/ready client request into a single A-channel Get or
// PutFullData beat and returns the matching D-channel AccessAck(Data) as a
// client response, with a response timeout so a hung slave cannot stall the
// client.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        client request handshake
//   req_write/addr/size/wdata  request fields (wdata already lane-aligned)
//   rsp_valid/rsp_ready        client response handshake
//   rsp_rdata/err/timeout      response fields (rdata is 0 for writes/errors)
//   stray                      sticky: D beat seen outside S_RESP
//   a_*                        TileLink A channel (master drives)
//   d_*                        TileLink D channel (master receives)
module tl_get_put_master
    import tl_get_put_master_pkg::*;
#(
    parameter int unsigned SOURCE_ID = 0,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [63:0]         req_addr,
    input  logic [1:0]          req_size,
    input  logic [63:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [63:0]         rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                stray,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [2:0]          a_opcode,
    output logic [2:0]          a_param,
    output logic [1:0]          a_size,
    output logic [TL_SRC_W-1:0] a_source,
    output logic [63:0]         a_address,
    output logic [7:0]          a_mask,
    output logic [63:0]         a_data,
    output logic                a_corrupt,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [TL_SRC_W-1:0] d_source,
    input  logic                d_denied,
    input  logic                d_corrupt,
    input  logic [63:0]         d_data
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TL_SRC_W-1:0] SRC = TL_SRC_W'(SOURCE_ID);

    tl_master_state_e state;
    logic [CNT_W-1:0] cnt;
    logic             d_err;
    logic             tmo_hit;

    assign req_ready = (state == S_IDLE);
    // D beats are always accepted; outside S_RESP they are dropped as stray.
    assign d_ready   = ENABLE;
    assign a_param   = '0;
    assign a_corrupt = DISABLE;

    always_comb begin
        d_err = d_denied | d_corrupt | (d_source != SRC);
        if (a_opcode == TL_GET) begin
            d_err = d_err | (d_opcode != TL_ACCESS_ACK_DATA);
        end else begin
            d_err = d_err | (d_opcode != TL_ACCESS_ACK);
        end
    end

    // Fires in the cycle the counter would step onto TIMEOUT-1; a d_valid in
    // that same cycle takes priority because it is tested first.
    assign tmo_hit = (TIMEOUT != 0) &&
                     ((32'(cnt) + 32'd1) >= (TIMEOUT - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a_valid     <= 1'b0;
            a_opcode    <= '0;
            a_size      <= '0;
            a_source    <= '0;
            a_address   <= '0;
            a_mask      <= '0;
            a_data      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            stray       <= 1'b0;
        end else begin
            if (d_valid && d_ready && (state != S_RESP)) begin
                stray <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_opcode  <= req_write ? TL_PUT_FULL_DATA : TL_GET;
                        a_size    <= req_size;
                        a_source  <= SRC;
                        a_address <= req_addr;
                        a_mask    <= tl_mask_f(req_addr[2:0], req_size);
                        a_data    <= req_write ? req_wdata : '0;
                        if (tl_aligned_f(req_addr[2:0], req_size)) begin
                            a_valid <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            state       <= S_DONE;
                        end
                    end
                end

                S_REQ: begin
                    if (a_ready) begin
                        a_valid <= 1'b0;
                        cnt     <= '0;
                        state   <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (d_valid) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= d_err;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= ((a_opcode == TL_GET) && !d_err) ? d_data : '0;
                        state       <= S_DONE;
                    end else if (tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
